// File: rtl/mdu_issue_queue.sv
// In-order issue queue for the multiply/divide unit. A shifting writeback-slot
// reservation vector keeps the MDU's two-cycle Hi/Lo writebacks from colliding.
module mdu_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int PRF_W      = 6,
    parameter int ROB_W      = 6,
    parameter int WAKE_PORTS = 4,
    parameter int MUL_LAT    = 3,
    parameter int DIV_LAT    = 18
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic                          enq_is_div,
    input  logic                          enq_signed,
    input  logic [PRF_W-1:0]              enq_prs0,
    input  logic [PRF_W-1:0]              enq_prs1,
    input  logic                          enq_busy0,
    input  logic                          enq_busy1,
    input  logic [PRF_W-1:0]              enq_pdst_hi,
    input  logic [PRF_W-1:0]              enq_pdst_lo,
    input  logic [ROB_W-1:0]              enq_rob_hi,
    input  logic [ROB_W-1:0]              enq_rob_lo,
    input  logic [WAKE_PORTS-1:0]         wake_valid,
    input  logic [WAKE_PORTS*PRF_W-1:0]   wake_tag,
    output logic                          issue_valid,
    output logic                          issue_is_div,
    output logic                          issue_signed,
    output logic [PRF_W-1:0]              issue_prs0,
    output logic [PRF_W-1:0]              issue_prs1,
    output logic [PRF_W-1:0]              issue_pdst_hi,
    output logic [PRF_W-1:0]              issue_pdst_lo,
    output logic [ROB_W-1:0]              issue_rob_hi,
    output logic [ROB_W-1:0]              issue_rob_lo,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RES_W = DIV_LAT + 2;

    typedef struct packed {
        logic             is_div;
        logic             is_sgn;
        logic [PRF_W-1:0] prs0;
        logic [PRF_W-1:0] prs1;
        logic [PRF_W-1:0] pdst_hi;
        logic [PRF_W-1:0] pdst_lo;
        logic [ROB_W-1:0] rob_hi;
        logic [ROB_W-1:0] rob_lo;
    } payload_t;

    function automatic logic wake_hit(
        input logic [PRF_W-1:0]            tag,
        input logic [WAKE_PORTS-1:0]       vld,
        input logic [WAKE_PORTS*PRF_W-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < WAKE_PORTS; i++) begin
            hit = hit | (vld[i] && (tags[i*PRF_W +: PRF_W] == tag));
        end
        return hit;
    endfunction

    payload_t         payload_r [DEPTH];
    logic             val_r     [DEPTH];
    logic             busy0_r   [DEPTH];
    logic             busy1_r   [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [RES_W-1:0] res_r;

    payload_t         enq_payload_s;
    logic             enq_busy0_s;
    logic             enq_busy1_s;
    logic             enq_go_s;
    logic             issue_go_s;
    logic             head_ready_s;
    logic             slot_free_s;
    logic [RES_W-1:0] res_shift_s;
    logic [RES_W-1:0] res_next_s;

    // Reset forces enq_ready low along with every other output
    assign enq_ready = rst && (count != CNT_W'(DEPTH));

    // Enqueue payload and busy bits, honouring a wakeup in the enqueue cycle
    always_comb begin
        enq_payload_s.is_div  = enq_is_div;
        enq_payload_s.is_sgn  = enq_signed;
        enq_payload_s.prs0    = enq_prs0;
        enq_payload_s.prs1    = enq_prs1;
        enq_payload_s.pdst_hi = enq_pdst_hi;
        enq_payload_s.pdst_lo = enq_pdst_lo;
        enq_payload_s.rob_hi  = enq_rob_hi;
        enq_payload_s.rob_lo  = enq_rob_lo;
        enq_busy0_s = enq_busy0 && !wake_hit(enq_prs0, wake_valid, wake_tag);
        enq_busy1_s = enq_busy1 && !wake_hit(enq_prs1, wake_valid, wake_tag);
        enq_go_s    = !flush && enq_valid && (count != CNT_W'(DEPTH));
    end

    // Issue decision against the reservation view of the cycle issue_valid will be high
    always_comb begin
        res_shift_s  = res_r >> 1'b1;
        res_next_s   = res_shift_s;
        head_ready_s = val_r[head_r] && !busy0_r[head_r] && !busy1_r[head_r];
        if (payload_r[head_r].is_div) begin
            slot_free_s = !res_shift_s[DIV_LAT] && !res_shift_s[DIV_LAT+1];
        end else begin
            slot_free_s = !res_shift_s[MUL_LAT] && !res_shift_s[MUL_LAT+1];
        end
        issue_go_s = !flush && head_ready_s && slot_free_s;
        if (issue_go_s && payload_r[head_r].is_div) begin
            res_next_s[DIV_LAT]   = 1'b1;
            res_next_s[DIV_LAT+1] = 1'b1;
        end else if (issue_go_s) begin
            res_next_s[MUL_LAT]   = 1'b1;
            res_next_s[MUL_LAT+1] = 1'b1;
        end else begin
            res_next_s = res_shift_s;
        end
    end

    // Queue storage, pointers, occupancy and per-source wakeup tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                payload_r[i] <= {$bits(payload_t){1'b0}};
                val_r[i]     <= 1'b0;
                busy0_r[i]   <= 1'b0;
                busy1_r[i]   <= 1'b0;
            end
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            count  <= {CNT_W{1'b0}};
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_r[i] <= 1'b0;
            end
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            count  <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq_go_s && (tail_r == PTR_W'(i))) begin
                    payload_r[i] <= enq_payload_s;
                    val_r[i]     <= 1'b1;
                    busy0_r[i]   <= enq_busy0_s;
                    busy1_r[i]   <= enq_busy1_s;
                end else begin
                    if (issue_go_s && (head_r == PTR_W'(i))) begin
                        val_r[i] <= 1'b0;
                    end else begin
                        val_r[i] <= val_r[i];
                    end
                    busy0_r[i] <= busy0_r[i] && !wake_hit(payload_r[i].prs0, wake_valid, wake_tag);
                    busy1_r[i] <= busy1_r[i] && !wake_hit(payload_r[i].prs1, wake_valid, wake_tag);
                end
            end
            if (enq_go_s) begin
                tail_r <= tail_r + PTR_W'(1'b1);
            end else begin
                tail_r <= tail_r;
            end
            if (issue_go_s) begin
                head_r <= head_r + PTR_W'(1'b1);
            end else begin
                head_r <= head_r;
            end
            case ({enq_go_s, issue_go_s})
                2'b10:   count <= count + CNT_W'(1'b1);
                2'b01:   count <= count - CNT_W'(1'b1);
                default: count <= count;
            endcase
        end
    end

    // Registered issue strobe; the payload holds its last value when nothing issues
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid   <= 1'b0;
            issue_is_div  <= 1'b0;
            issue_signed  <= 1'b0;
            issue_prs0    <= {PRF_W{1'b0}};
            issue_prs1    <= {PRF_W{1'b0}};
            issue_pdst_hi <= {PRF_W{1'b0}};
            issue_pdst_lo <= {PRF_W{1'b0}};
            issue_rob_hi  <= {ROB_W{1'b0}};
            issue_rob_lo  <= {ROB_W{1'b0}};
        end else if (issue_go_s) begin
            issue_valid   <= 1'b1;
            issue_is_div  <= payload_r[head_r].is_div;
            issue_signed  <= payload_r[head_r].is_sgn;
            issue_prs0    <= payload_r[head_r].prs0;
            issue_prs1    <= payload_r[head_r].prs1;
            issue_pdst_hi <= payload_r[head_r].pdst_hi;
            issue_pdst_lo <= payload_r[head_r].pdst_lo;
            issue_rob_hi  <= payload_r[head_r].rob_hi;
            issue_rob_lo  <= payload_r[head_r].rob_lo;
        end else begin
            issue_valid <= 1'b0;
        end
    end

    // Writeback-slot reservations keep shifting through flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_r <= {RES_W{1'b0}};
        end else begin
            res_r <= res_next_s;
        end
    end

endmodule

// File: tb/tb_mdu_issue_queue.sv
// Randomized and directed bench for mdu_issue_queue against a queue model that
// books absolute writeback cycles.
module tb_mdu_issue_queue;

    localparam int DEPTH   = 4;
    localparam int PRF_W   = 6;
    localparam int ROB_W   = 6;
    localparam int WP      = 4;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 18;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 enq_valid;
    logic                 enq_ready;
    logic                 enq_is_div;
    logic                 enq_signed;
    logic [PRF_W-1:0]     enq_prs0;
    logic [PRF_W-1:0]     enq_prs1;
    logic                 enq_busy0;
    logic                 enq_busy1;
    logic [PRF_W-1:0]     enq_pdst_hi;
    logic [PRF_W-1:0]     enq_pdst_lo;
    logic [ROB_W-1:0]     enq_rob_hi;
    logic [ROB_W-1:0]     enq_rob_lo;
    logic [WP-1:0]        wake_valid;
    logic [WP*PRF_W-1:0]  wake_tag;
    logic                 issue_valid;
    logic                 issue_is_div;
    logic                 issue_signed;
    logic [PRF_W-1:0]     issue_prs0;
    logic [PRF_W-1:0]     issue_prs1;
    logic [PRF_W-1:0]     issue_pdst_hi;
    logic [PRF_W-1:0]     issue_pdst_lo;
    logic [ROB_W-1:0]     issue_rob_hi;
    logic [ROB_W-1:0]     issue_rob_lo;
    logic [$clog2(DEPTH):0] count;

    mdu_issue_queue #(
        .DEPTH(DEPTH), .PRF_W(PRF_W), .ROB_W(ROB_W),
        .WAKE_PORTS(WP), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_is_div(enq_is_div), .enq_signed(enq_signed),
        .enq_prs0(enq_prs0), .enq_prs1(enq_prs1),
        .enq_busy0(enq_busy0), .enq_busy1(enq_busy1),
        .enq_pdst_hi(enq_pdst_hi), .enq_pdst_lo(enq_pdst_lo),
        .enq_rob_hi(enq_rob_hi), .enq_rob_lo(enq_rob_lo),
        .wake_valid(wake_valid), .wake_tag(wake_tag),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div),
        .issue_signed(issue_signed), .issue_prs0(issue_prs0),
        .issue_prs1(issue_prs1), .issue_pdst_hi(issue_pdst_hi),
        .issue_pdst_lo(issue_pdst_lo), .issue_rob_hi(issue_rob_hi),
        .issue_rob_lo(issue_rob_lo), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             is_div;
        logic             sgn;
        logic [PRF_W-1:0] prs0;
        logic [PRF_W-1:0] prs1;
        logic [PRF_W-1:0] pdst_hi;
        logic [PRF_W-1:0] pdst_lo;
        logic [ROB_W-1:0] rob_hi;
        logic [ROB_W-1:0] rob_lo;
    } pay_t;

    typedef struct packed {
        pay_t p;
        logic b0;
        logic b1;
    } ment_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    ment_t mq[$];
    pay_t  m_last;
    logic  m_iv;
    bit    booked[int];
    bit    seen_wb[int];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit woke(input logic [PRF_W-1:0] t);
        for (int i = 0; i < WP; i++) begin
            if (wake_valid[i] && (wake_tag[i*PRF_W +: PRF_W] == t)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_iv   = 1'b0;
        m_last = '0;
        booked.delete();
        seen_wb.delete();
    endtask

    // Advance the model across one clock edge using the inputs now driven
    task automatic model_step();
        int    lat;
        int    slot;
        bit    ready_pre;
        ment_t e;
        if (rst !== 1'b1) begin
            model_reset();
            cyc++;
            return;
        end
        ready_pre = (mq.size() != DEPTH);
        m_iv = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && !mq[0].b0 && !mq[0].b1) begin
                lat  = mq[0].p.is_div ? DIV_LAT : MUL_LAT;
                slot = cyc + 1 + lat;
                if (!booked.exists(slot) && !booked.exists(slot + 1)) begin
                    booked[slot]     = 1'b1;
                    booked[slot + 1] = 1'b1;
                    m_iv   = 1'b1;
                    m_last = mq[0].p;
                    void'(mq.pop_front());
                end
            end
            foreach (mq[i]) begin
                if (woke(mq[i].p.prs0)) mq[i].b0 = 1'b0;
                if (woke(mq[i].p.prs1)) mq[i].b1 = 1'b0;
            end
            if (enq_valid && ready_pre) begin
                e.p.is_div  = enq_is_div;
                e.p.sgn     = enq_signed;
                e.p.prs0    = enq_prs0;
                e.p.prs1    = enq_prs1;
                e.p.pdst_hi = enq_pdst_hi;
                e.p.pdst_lo = enq_pdst_lo;
                e.p.rob_hi  = enq_rob_hi;
                e.p.rob_lo  = enq_rob_lo;
                e.b0 = enq_busy0 && !woke(enq_prs0);
                e.b1 = enq_busy1 && !woke(enq_prs1);
                mq.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic check_outputs();
        int lat;
        chk("issue_valid", 64'(issue_valid), 64'(m_iv));
        chk("count", 64'(count), 64'(mq.size()));
        chk("enq_ready", 64'(enq_ready), 64'((rst === 1'b1) && (mq.size() != DEPTH)));
        chk("issue_fields", 64'({issue_is_div, issue_signed, issue_prs0, issue_prs1,
                                issue_pdst_hi, issue_pdst_lo, issue_rob_hi, issue_rob_lo}),
            64'(m_last));
        if (issue_valid === 1'b1) begin
            lat = issue_is_div ? DIV_LAT : MUL_LAT;
            chk("wb_collision", 64'(seen_wb.exists(cyc + lat) || seen_wb.exists(cyc + lat + 1)), 64'(0));
            seen_wb[cyc + lat]     = 1'b1;
            seen_wb[cyc + lat + 1] = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        enq_valid  = 1'b0;
        wake_valid = 4'b0000;
        flush      = 1'b0;
    endtask

    task automatic drive_enq(input logic dv, input logic sg,
                             input logic [PRF_W-1:0] p0, input logic [PRF_W-1:0] p1,
                             input logic b0, input logic b1,
                             input logic [PRF_W-1:0] dh, input logic [PRF_W-1:0] dl,
                             input logic [ROB_W-1:0] rh, input logic [ROB_W-1:0] rl);
        enq_valid   = 1'b1;
        enq_is_div  = dv;
        enq_signed  = sg;
        enq_prs0    = p0;
        enq_prs1    = p1;
        enq_busy0   = b0;
        enq_busy1   = b1;
        enq_pdst_hi = dh;
        enq_pdst_lo = dl;
        enq_rob_hi  = rh;
        enq_rob_lo  = rl;
    endtask

    // Count edges (the first one carries whatever is driven now) until issue_valid
    task automatic wait_issue(input int max, output int n);
        n = 0;
        for (int k = 0; k < max; k++) begin
            tick();
            n++;
            idle();
            if (issue_valid === 1'b1) return;
        end
        n = max + 1;
    endtask

    int n;
    int issued;

    initial begin
        idle();
        rst = 1'b0;
        drive_enq(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        enq_valid = 1'b0;
        wake_tag  = '0;
        tick();
        tick();
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ready", 64'(enq_ready), 64'(0));
        rst = 1'b1;
        tick();

        // Ready multiply: issue_valid two edges after the enqueue
        drive_enq(1'b0, 1'b0, 6'd1, 6'd2, 1'b0, 1'b0, 6'd5, 6'd6, 6'd3, 6'd4);
        wait_issue(10, n);
        chk("mul_lat", 64'(n), 64'(2));
        chk("mul_dst", 64'({issue_pdst_hi, issue_pdst_lo, issue_rob_hi, issue_rob_lo}),
            64'({6'd5, 6'd6, 6'd3, 6'd4}));
        tick();
        chk("mul_drain", 64'(count), 64'(0));

        // Divide waiting on prs1=9, woken on port 2 three cycles after enqueue
        drive_enq(1'b1, 1'b1, 6'd8, 6'd9, 1'b0, 1'b1, 6'd10, 6'd11, 6'd12, 6'd13);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_early_issue", 64'(issue_valid), 64'(0));
        end
        wake_valid = 4'b0100;
        wake_tag[2*PRF_W +: PRF_W] = 6'd9;
        wait_issue(10, n);
        chk("wake_lat", 64'(n), 64'(2));

        // Wakeup in the enqueue cycle itself
        drive_enq(1'b1, 1'b0, 6'd8, 6'd9, 1'b0, 1'b1, 6'd14, 6'd15, 6'd16, 6'd17);
        wake_valid = 4'b0100;
        wake_tag[2*PRF_W +: PRF_W] = 6'd9;
        wait_issue(10, n);
        chk("enq_wake_lat", 64'(n), 64'(2));

        // Divide then a multiply whose slots collide with the divide's Hi/Lo
        repeat (25) tick();
        drive_enq(1'b1, 1'b0, 6'd1, 6'd2, 1'b0, 1'b0, 6'd20, 6'd21, 6'd22, 6'd23);
        wait_issue(10, n);
        chk("div_lat", 64'(n), 64'(2));
        repeat (12) tick();
        drive_enq(1'b0, 1'b1, 6'd3, 6'd4, 1'b0, 1'b0, 6'd24, 6'd25, 6'd26, 6'd27);
        wait_issue(20, n);
        chk("mul_stall", 64'(n), 64'(DIV_LAT - 1 - 12));

        // Two batches of four busy entries: full queue, ignored 5th, FIFO drain with wrap
        repeat (25) tick();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < DEPTH; k++) begin
                drive_enq(1'b0, 1'(k), 6'd30, 6'(k), 1'b1, 1'b0,
                          6'(40 + k), 6'(48 + k), 6'(b*8 + k*2), 6'(b*8 + k*2 + 1));
                tick();
            end
            chk("full_count", 64'(count), 64'(DEPTH));
            chk("full_ready", 64'(enq_ready), 64'(0));
            drive_enq(1'b0, 1'b0, 6'd1, 6'd1, 1'b0, 1'b0, 6'd60, 6'd61, 6'd63, 6'd62);
            tick();
            chk("full_ignore", 64'(count), 64'(DEPTH));
            idle();
            wake_valid = 4'b0001;
            wake_tag[0 +: PRF_W] = 6'd30;
            issued = 0;
            for (int c = 0; c < 40 && issued < DEPTH; c++) begin
                tick();
                idle();
                if (issue_valid === 1'b1) begin
                    chk("fifo_rob", 64'(issue_rob_hi), 64'(b*8 + issued*2));
                    issued++;
                end
            end
            chk("batch_issued", 64'(issued), 64'(DEPTH));
        end

        // Flush with three queued entries and an enqueue offered in the flush cycle
        for (int k = 0; k < 3; k++) begin
            drive_enq(1'b0, 1'b0, 6'd31, 6'd2, 1'b1, 1'b0, 6'd1, 6'd2, 6'(k), 6'd0);
            tick();
        end
        drive_enq(1'b0, 1'b0, 6'd1, 6'd2, 1'b0, 1'b0, 6'd7, 6'd7, 6'd7, 6'd7);
        flush = 1'b1;
        tick();
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_iv", 64'(issue_valid), 64'(0));
        chk("flush_ready", 64'(enq_ready), 64'(1));
        idle();
        repeat (6) tick();
        drive_enq(1'b0, 1'b0, 6'd3, 6'd4, 1'b0, 1'b0, 6'd33, 6'd34, 6'd35, 6'd36);
        wait_issue(10, n);
        chk("post_flush_lat", 64'(n), 64'(2));

        // Asynchronous reset between clock edges with work in flight
        repeat (6) tick();
        drive_enq(1'b0, 1'b0, 6'd1, 6'd2, 1'b0, 1'b0, 6'd41, 6'd42, 6'd43, 6'd44);
        tick();
        drive_enq(1'b1, 1'b0, 6'd5, 6'd6, 1'b1, 1'b0, 6'd45, 6'd46, 6'd47, 6'd48);
        tick();
        idle();
        tick();
        #3;
        rst = 1'b0;
        #1;
        chk("arst_iv", 64'(issue_valid), 64'(0));
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_ready", 64'(enq_ready), 64'(0));
        chk("arst_fields", 64'({issue_is_div, issue_signed, issue_prs0, issue_prs1,
                               issue_pdst_hi, issue_pdst_lo, issue_rob_hi, issue_rob_lo}), 64'(0));
        model_reset();
        tick();
        tick();
        rst = 1'b1;
        tick();
        drive_enq(1'b0, 1'b0, 6'd1, 6'd2, 1'b0, 1'b0, 6'd51, 6'd52, 6'd53, 6'd54);
        wait_issue(10, n);
        chk("post_rst_lat", 64'(n), 64'(2));

        // Random traffic against the model
        for (int r = 0; r < 400; r++) begin
            enq_valid   = 1'($urandom_range(0, 1));
            enq_is_div  = 1'($urandom_range(0, 3) == 0);
            enq_signed  = 1'($urandom_range(0, 1));
            enq_prs0    = 6'($urandom_range(0, 7));
            enq_prs1    = 6'($urandom_range(0, 7));
            enq_busy0   = 1'($urandom_range(0, 2) == 0);
            enq_busy1   = 1'($urandom_range(0, 2) == 0);
            enq_pdst_hi = 6'($urandom);
            enq_pdst_lo = 6'($urandom);
            enq_rob_hi  = 6'($urandom);
            enq_rob_lo  = 6'($urandom);
            wake_valid  = 4'($urandom_range(0, 15));
            for (int i = 0; i < WP; i++) begin
                wake_tag[i*PRF_W +: PRF_W] = 6'($urandom_range(0, 7));
            end
            flush = 1'($urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        repeat (60) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
